// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline advance/hold/flush sequencing for load-use, branch, fetch-miss and dmem-wait
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = 31,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             if_id_use_rs2,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic pend, pend_nx, lu_hit, in_lu, pw, iw, ifl, efl, ph;
  // a dmem wait that interrupted a load-use stall resumes it via pend
  always_comb begin
    lu_hit = id_ex_mem_read && id_ex_rd != REG_W'(ZERO_REG) &&
             (id_ex_rd == if_id_rs1 || (if_id_use_rs2 && id_ex_rd == if_id_rs2));
    in_lu = state == LU_STALL || (state == MEM_WAIT && pend);
    pw = 1'b1;
    iw = 1'b1;
    ifl = 1'b0;
    efl = 1'b0;
    ph = 1'b0;
    state_nx = RUN;
    cnt_nx = cnt;
    pend_nx = 1'b0;
    if (dmem_busy) begin
      pw = 1'b0;
      iw = 1'b0;
      ph = 1'b1;
      state_nx = MEM_WAIT;
      pend_nx = in_lu;
    end else if (branch_taken) begin
      ifl = 1'b1;
      efl = 1'b1;
      cnt_nx = 2'd0;
    end else if (in_lu) begin
      pw = 1'b0;
      iw = 1'b0;
      efl = 1'b1;
      cnt_nx = cnt - 2'd1;
      state_nx = cnt <= 2'd1 ? RUN : LU_STALL;
    end else if (lu_hit) begin
      pw = 1'b0;
      iw = 1'b0;
      efl = 1'b1;
      cnt_nx = 2'(LU_BUBBLES - 1);
      state_nx = LU_BUBBLES > 1 ? LU_STALL : RUN;
    end else if (!imem_ready) begin
      pw = 1'b0;
      ifl = 1'b1;
    end
  end
  assign pc_write    = !reset && pw;
  assign if_id_write = !reset && iw;
  assign if_id_flush = reset || ifl;
  assign id_ex_flush = reset || efl;
  assign pipe_hold   = !reset && ph;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      cnt <= 2'd0;
      pend <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      stall_cycles <= (!pw && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks on a default instance (a) and a LU_BUBBLES=3, CNT_W=4 instance (b)
module tb_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic if_id_use_rs2, id_ex_mem_read, branch_taken, imem_ready, dmem_busy;
  logic pw_a, iw_a, ifl_a, efl_a, ph_a, pw_b, iw_b, ifl_b, efl_b, ph_b;
  logic [31:0] sc_a;
  logic [3:0] sc_b;
  logic [4:0] oa, ob;
  int checks = 0, errors = 0;
  assign oa = {pw_a, iw_a, ifl_a, efl_a, ph_a};
  assign ob = {pw_b, iw_b, ifl_b, efl_b, ph_b};
  always #5 clk = ~clk;
  hazard_ctrl u_a (
    .clk(clk), .reset(reset), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs2(if_id_use_rs2), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_write(pw_a), .if_id_write(iw_a), .if_id_flush(ifl_a), .id_ex_flush(efl_a),
    .pipe_hold(ph_a), .stall_cycles(sc_a));
  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs2(if_id_use_rs2), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_write(pw_b), .if_id_write(iw_b), .if_id_flush(ifl_b), .id_ex_flush(efl_b),
    .pipe_hold(ph_b), .stall_cycles(sc_b));

  task automatic idle();
    if_id_rs1 = 5'd1; if_id_rs2 = 5'd2; if_id_use_rs2 = 0; id_ex_mem_read = 0;
    id_ex_rd = 5'd0; branch_taken = 0; imem_ready = 1; dmem_busy = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic load_hazard();
    id_ex_mem_read = 1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #1;
    checks++; if (oa !== 5'b00110) begin errors++; $display("FAIL reset_outs got %b exp 00110", oa); end
    checks++; if (sc_a !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sc_a); end
  endtask

  task automatic test_load_use();
    do_reset();
    load_hazard(); #1;
    checks++; if (oa !== 5'b00010) begin errors++; $display("FAIL lu1_stall got %b exp 00010", oa); end
    @(negedge clk); idle(); #1;
    checks++; if (oa !== 5'b11000) begin errors++; $display("FAIL lu1_resume got %b exp 11000", oa); end
    checks++; if (sc_a !== 32'd1) begin errors++; $display("FAIL lu1_cnt got %0d exp 1", sc_a); end
  endtask

  task automatic test_no_stall();
    do_reset();
    id_ex_mem_read = 1; id_ex_rd = 5'd31; if_id_rs1 = 5'd31; #1;
    checks++; if (oa !== 5'b11000) begin errors++; $display("FAIL xzr_nostall got %b exp 11000", oa); end
    @(negedge clk); id_ex_rd = 5'd7; if_id_rs1 = 5'd1; if_id_rs2 = 5'd7; #1;
    checks++; if (oa !== 5'b11000) begin errors++; $display("FAIL rs2_unused got %b exp 11000", oa); end
    if_id_use_rs2 = 1; #1;
    checks++; if (oa !== 5'b00010) begin errors++; $display("FAIL rs2_used got %b exp 00010", oa); end
    @(negedge clk); idle(); #1;
    checks++; if (sc_a !== 32'd1) begin errors++; $display("FAIL nostall_cnt got %0d exp 1", sc_a); end
  endtask

  task automatic test_lu3();
    do_reset();
    load_hazard(); #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL lu3_c1 got %b exp 00010", ob); end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); idle(); #1;
      checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL lu3_c%0d got %b exp 00010", i, ob); end
    end
    @(negedge clk); #1;
    checks++; if (ob !== 5'b11000) begin errors++; $display("FAIL lu3_done got %b exp 11000", ob); end
    checks++; if (sc_b !== 4'd3) begin errors++; $display("FAIL lu3_cnt got %0d exp 3", sc_b); end
    @(negedge clk); load_hazard(); #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL lu3br_c1 got %b exp 00010", ob); end
    @(negedge clk); idle(); branch_taken = 1; #1;
    checks++; if (ob !== 5'b11110) begin errors++; $display("FAIL lu3br_flush got %b exp 11110", ob); end
    @(negedge clk); idle(); #1;
    checks++; if (ob !== 5'b11000) begin errors++; $display("FAIL lu3br_run got %b exp 11000", ob); end
    checks++; if (sc_b !== 4'd4) begin errors++; $display("FAIL lu3br_cnt got %0d exp 4", sc_b); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      dmem_busy = 1; branch_taken = 1; #1;
      checks++; if (oa !== 5'b00001) begin errors++; $display("FAIL mw_hold%0d got %b exp 00001", i, oa); end
      @(negedge clk);
    end
    dmem_busy = 0; #1;
    checks++; if (oa !== 5'b11110) begin errors++; $display("FAIL mw_flush got %b exp 11110", oa); end
    checks++; if (sc_a !== 32'd4) begin errors++; $display("FAIL mw_cnt got %0d exp 4", sc_a); end
    @(negedge clk); idle();
    do_reset();
    load_hazard(); #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL mwlu_c1 got %b exp 00010", ob); end
    @(negedge clk); idle(); dmem_busy = 1;
    @(negedge clk); #1;
    checks++; if (ob !== 5'b00001) begin errors++; $display("FAIL mwlu_hold got %b exp 00001", ob); end
    @(negedge clk); dmem_busy = 0; #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL mwlu_resume1 got %b exp 00010", ob); end
    @(negedge clk); #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL mwlu_resume2 got %b exp 00010", ob); end
    @(negedge clk); #1;
    checks++; if (ob !== 5'b11000) begin errors++; $display("FAIL mwlu_run got %b exp 11000", ob); end
  endtask

  task automatic test_imem_miss();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      imem_ready = 0; #1;
      checks++; if (oa !== 5'b01100) begin errors++; $display("FAIL imiss%0d got %b exp 01100", i, oa); end
      @(negedge clk);
    end
    imem_ready = 1; #1;
    checks++; if (oa !== 5'b11000) begin errors++; $display("FAIL imiss_run got %b exp 11000", oa); end
    checks++; if (sc_a !== 32'd2) begin errors++; $display("FAIL imiss_cnt got %0d exp 2", sc_a); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    load_hazard();
    @(negedge clk); idle(); #1;
    checks++; if (ob !== 5'b00010) begin errors++; $display("FAIL rms_stall got %b exp 00010", ob); end
    #2 reset = 1; #1;
    checks++; if (ob !== 5'b00110) begin errors++; $display("FAIL rms_forced got %b exp 00110", ob); end
    checks++; if (sc_b !== 4'd0) begin errors++; $display("FAIL rms_cnt_async got %0d exp 0", sc_b); end
    @(negedge clk); reset = 0; #1;
    checks++; if (ob !== 5'b11000) begin errors++; $display("FAIL rms_run got %b exp 11000", ob); end
    checks++; if (sc_b !== 4'd0) begin errors++; $display("FAIL rms_cnt got %0d exp 0", sc_b); end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    checks++; if (sc_b !== 4'd15) begin errors++; $display("FAIL sat_b got %0d exp 15", sc_b); end
    checks++; if (sc_a !== 32'd20) begin errors++; $display("FAIL sat_a got %0d exp 20", sc_a); end
    checks++; if (ob !== 5'b01100) begin errors++; $display("FAIL sat_outs got %b exp 01100", ob); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_lu3();
    test_mem_wait();
    test_imem_miss();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
